// File: rtl/iecdrv_mem_arb.sv
// Two-requester arbiter for a single registered-address/registered-data RAM port.
// Requester A has priority. B is forced after STARVE_LIM back-to-back A grants made while B is waiting.
module iecdrv_mem_arb #(
    parameter int DATAWIDTH  = 8,
    parameter int ADDRWIDTH  = 11,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDRWIDTH-1:0] a_addr,
    input  logic [DATAWIDTH-1:0] a_wdata,
    output logic                 a_ack,
    output logic [DATAWIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDRWIDTH-1:0] b_addr,
    input  logic [DATAWIDTH-1:0] b_wdata,
    output logic                 b_ack,
    output logic [DATAWIDTH-1:0] b_rdata,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_data,
    output logic                 mem_wren,
    input  logic [DATAWIDTH-1:0] mem_q,
    output logic                 busy,
    output logic                 owner
);

    localparam int LAT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LAT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_reg, state_next;
    logic [LAT_W-1:0]      lat_cnt_reg, lat_cnt_next;
    logic [STARVE_W-1:0]   starve_cnt_reg, starve_cnt_next;
    logic                  we_reg, we_next;
    logic                  owner_reg, owner_next;
    logic                  busy_reg, busy_next;
    logic                  a_ack_reg, a_ack_next;
    logic                  b_ack_reg, b_ack_next;
    logic [DATAWIDTH-1:0]  a_rdata_reg, a_rdata_next;
    logic [DATAWIDTH-1:0]  b_rdata_reg, b_rdata_next;
    logic [ADDRWIDTH-1:0]  mem_addr_reg, mem_addr_next;
    logic [DATAWIDTH-1:0]  mem_data_reg, mem_data_next;
    logic                  mem_wren_reg, mem_wren_next;
    logic                  grant_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            we_reg         <= 1'b0;
            owner_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            a_ack_reg      <= 1'b0;
            b_ack_reg      <= 1'b0;
            a_rdata_reg    <= '0;
            b_rdata_reg    <= '0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            mem_wren_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lat_cnt_reg    <= lat_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            we_reg         <= we_next;
            owner_reg      <= owner_next;
            busy_reg       <= busy_next;
            a_ack_reg      <= a_ack_next;
            b_ack_reg      <= b_ack_next;
            a_rdata_reg    <= a_rdata_next;
            b_rdata_reg    <= b_rdata_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
            mem_wren_reg   <= mem_wren_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lat_cnt_next    = lat_cnt_reg;
        starve_cnt_next = starve_cnt_reg;
        we_next         = we_reg;
        owner_next      = owner_reg;
        busy_next       = busy_reg;
        a_ack_next      = a_ack_reg;
        b_ack_next      = b_ack_reg;
        a_rdata_next    = a_rdata_reg;
        b_rdata_next    = b_rdata_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        mem_wren_next   = mem_wren_reg;
        grant_b         = b_req && (!a_req || starve_cnt_reg == STARVE_MAX);

        case (state_reg)
            IDLE: begin
                if (a_req || b_req) begin
                    mem_addr_next = grant_b ? b_addr  : a_addr;
                    mem_data_next = grant_b ? b_wdata : a_wdata;
                    mem_wren_next = grant_b ? b_we    : a_we;
                    we_next       = grant_b ? b_we    : a_we;
                    owner_next    = grant_b;
                    busy_next     = 1'b1;
                    lat_cnt_next  = '0;
                    state_next    = WAIT;
                    // Count only A wins that made a waiting B lose; saturate at the limit.
                    if (grant_b || !b_req)
                        starve_cnt_next = '0;
                    else if (starve_cnt_reg != STARVE_MAX)
                        starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
                end
            end
            WAIT: begin
                mem_wren_next = 1'b0;
                if (lat_cnt_reg == LAT_LAST) begin
                    if (owner_reg) begin
                        b_ack_next = 1'b1;
                        if (!we_reg)
                            b_rdata_next = mem_q;
                    end else begin
                        a_ack_next = 1'b1;
                        if (!we_reg)
                            a_rdata_next = mem_q;
                    end
                    state_next = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + LAT_W'(1);
                end
            end
            RESP: begin
                a_ack_next = 1'b0;
                b_ack_next = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign a_ack    = a_ack_reg;
    assign b_ack    = b_ack_reg;
    assign a_rdata  = a_rdata_reg;
    assign b_rdata  = b_rdata_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign mem_wren = mem_wren_reg;
    assign busy     = busy_reg;
    assign owner    = owner_reg;

endmodule
